mux_n_para_1_registrado: RTL



---
 rtl/mux_n_para_1_registrado.sv | 110 +++++++++++
 1 files changed

// File: rtl/mux_n_para_1_registrado.sv
// ---------------------------------------------------------------------------
// mux_n_para_1_registrado
//
// Registered N:1 channel selector for the 8-bit nRisc datapath. Several
// producers (register-file read, immediate, memory, PC+1) offer data with a
// valid/accept handshake; one of them is granted per cycle and its data is
// captured into an output register that honours downstream backpressure.
//
// Two selection modes:
//   - fixed       : the channel indexed by Selecao is granted when valid
//   - round-robin : the first valid channel after the last one granted
//
// Ports:
//   Clock           in   rising-edge clock
//   Reset           in   asynchronous, active-high reset
//   Entradas        in   flattened channel data, channel k at [k*LARGURA +: LARGURA]
//   EntradasValidas in   per-channel valid
//   EntradasAceitas out  per-channel accept (one-hot or zero, combinational)
//   Selecao         in   channel index used in fixed mode
//   ModoRoundRobin  in   0 = fixed select, 1 = round-robin
//   SaidaPronta     in   downstream ready
//   SaidaMux        out  registered selected data
//   SaidaValida     out  registered output valid
//   CanalSaida      out  index of the channel held in SaidaMux
// ---------------------------------------------------------------------------
module mux_n_para_1_registrado #(
  parameter  int LARGURA  = 8,
  parameter  int CANAIS   = 4,
  localparam int LARG_SEL = $clog2(CANAIS)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [CANAIS*LARGURA-1:0]   Entradas,
  input  logic [CANAIS-1:0]           EntradasValidas,
  output logic [CANAIS-1:0]           EntradasAceitas,
  input  logic [LARG_SEL-1:0]         Selecao,
  input  logic                        ModoRoundRobin,
  input  logic                        SaidaPronta,
  output logic [LARGURA-1:0]          SaidaMux,
  output logic                        SaidaValida,
  output logic [LARG_SEL-1:0]         CanalSaida
);

  logic [LARG_SEL-1:0] ultimo_concedido;
  logic                carrega;
  logic                grant_valid;
  logic [LARG_SEL-1:0] grant_idx;

  // The output register can take a new word when it is empty or when the
  // word it holds is being consumed in this same cycle.
  assign carrega = !SaidaValida || SaidaPronta;

  // Grant selection. In round-robin mode the scan runs from the highest
  // offset down to offset 1 so that the last hit is the channel closest to
  // the one after ultimo_concedido, giving first-match-with-wrap priority.
  // Fixed mode range-checks Selecao first so an out-of-range index (only
  // possible when CANAIS is not a power of two) yields no grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (ModoRoundRobin) begin
      for (int i = CANAIS; i >= 1; i--) begin
        if (EntradasValidas[(int'(ultimo_concedido) + i) % CANAIS]) begin
          grant_valid = 1'b1;
          grant_idx   = LARG_SEL'((int'(ultimo_concedido) + i) % CANAIS);
        end
      end
    end else if (int'(Selecao) < CANAIS) begin
      if (EntradasValidas[Selecao]) begin
        grant_valid = 1'b1;
        grant_idx   = Selecao;
      end
    end
  end

  // Accept goes to the granted channel only when the register can load, and
  // is forced low while reset is held so no producer believes it was taken.
  always_comb begin
    EntradasAceitas = '0;
    for (int k = 0; k < CANAIS; k++) begin
      EntradasAceitas[k] = !Reset && carrega && grant_valid &&
                           (int'(grant_idx) == k);
    end
  end

  // Output register and round-robin pointer. A load cycle without a grant
  // drains the register (valid drops) but keeps the last data and channel.
  // The pointer resets to the last channel so the first search starts at 0,
  // and only round-robin transfers move it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      SaidaMux         <= '0;
      SaidaValida      <= 1'b0;
      CanalSaida       <= '0;
      ultimo_concedido <= LARG_SEL'(CANAIS - 1);
    end else if (carrega) begin
      if (grant_valid) begin
        SaidaMux    <= Entradas[int'(grant_idx)*LARGURA +: LARGURA];
        CanalSaida  <= grant_idx;
        SaidaValida <= 1'b1;
        if (ModoRoundRobin) begin
          ultimo_concedido <= grant_idx;
        end
      end else begin
        SaidaValida <= 1'b0;
      end
    end
  end

endmodule
